// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector slice: parameter defaults and
// the upstream 1011 detector's state type.
package seq_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;

    // State of the upstream 1011 detector; named after the prefix matched so far.
    typedef enum logic [2:0] {
        DET_IDLE  = 3'd0,
        DET_S1    = 3'd1,
        DET_S10   = 3'd2,
        DET_S101  = 3'd3,
        DET_S1011 = 3'd4
    } det_state_t;

endpackage

// File: rtl/seq_evt_fifo.sv
// Synchronous first-word-fall-through FIFO; the extra wrap bit on each pointer
// is what tells full apart from empty when the index bits match.
module seq_evt_fifo
    import seq_pkg::*;
#(
    parameter int WIDTH = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot this cycle, so a push into a full FIFO may reuse it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/seq_event_logger.sv
// Timestamps each detector pulse, queues it for a consumer, and keeps
// saturating event/drop statistics with a sticky overflow flag.
module seq_event_logger
    import seq_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det,
    input  logic             clear_stats,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TS_W-1:0]  ev_ts,
    output logic [CNT_W-1:0] ev_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);

    logic [TS_W-1:0]  ts;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic [CNT_W-1:0] ev_count_nxt;
    logic [CNT_W-1:0] drop_count_nxt;
    logic             overflow_nxt;

    // Handshake: the head transfers on a cycle where ev_valid and ev_ready are
    // both high; ev_valid never depends on ev_ready, and ev_ts holds until taken.
    assign ev_valid = ~fifo_empty;
    assign pop      = ev_valid & ev_ready;
    assign push     = det & (~fifo_full | pop);
    assign drop     = det & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) ts <= '0;
        else     ts <= ts + TS_W'(1);
    end

    seq_evt_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ts),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (ev_ts)
    );

    // Clear happens first so that an event in the clearing cycle is still counted.
    always_comb begin
        ev_count_nxt   = ev_count;
        drop_count_nxt = drop_count;
        overflow_nxt   = overflow;
        if (clear_stats) begin
            ev_count_nxt   = '0;
            drop_count_nxt = '0;
            overflow_nxt   = 1'b0;
        end
        if (det && (ev_count_nxt != {CNT_W{1'b1}})) begin
            ev_count_nxt = ev_count_nxt + CNT_W'(1);
        end
        if (drop) begin
            overflow_nxt = 1'b1;
            if (drop_count_nxt != {CNT_W{1'b1}}) begin
                drop_count_nxt = drop_count_nxt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_count   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            ev_count   <= ev_count_nxt;
            drop_count <= drop_count_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule
